// File: rtl/aes_word_io.sv
// Word-serial packer/unpacker around a pipelined AES-128 encryption core.
// Build macro AES_IO_IDLE_ZERO_EN: drive core_state to zero outside issue cycles.
module aes_word_io #(
  parameter int unsigned CORE_LATENCY = 21,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_key,
  output logic [127:0] core_state,
  output logic [127:0] core_key,
  input  logic [127:0] core_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         busy
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = CW + 2;

  logic [1:0]              cnt_q, cnt_d;
  logic                    type_q, type_d;
  logic [95:0]             buf_q, buf_d;
  logic [127:0]            state_q, state_d, key_q, key_d;
  logic                    issue_q, issue_d;
  logic [CORE_LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [CW-1:0]           inflight_q, inflight_d, fcnt_q, fcnt_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [127:0]            mem_q [FIFO_DEPTH];
  logic [1:0]              oidx_q, oidx_d;
  logic                    ovalid_q, ovalid_d, olast_q, olast_d;
  logic                    busy_q, busy_d, rdy_q, rdy_d;
  logic [31:0]             odata_q, odata_d;
  logic                    accept, push, pop;
  logic [127:0]            head;

  assign accept     = in_valid & in_ready;
  assign push       = vld_sr_q[CORE_LATENCY-1];
  assign pop        = ovalid_q & out_ready & (oidx_q == 2'd3);
  assign in_ready   = ~rst & rdy_q;
  assign core_state = state_q;
  assign core_key   = key_q;
  assign out_valid  = ovalid_q;
  assign out_data   = odata_q;
  assign out_last   = olast_q;
  assign busy       = busy_q;

  // Next-state: input assembly, valid tracking, result FIFO and output serializer
  always_comb begin
    cnt_d   = cnt_q;
    type_d  = type_q;
    buf_d   = buf_q;
    key_d   = key_q;
`ifdef AES_IO_IDLE_ZERO_EN
    state_d = '0;
`else
    state_d = state_q;
`endif
    issue_d = 1'b0;
    if (accept) begin
      cnt_d = cnt_q + 2'd1;
      unique case (cnt_q)
        2'd0: begin
          buf_d[95:64] = in_data;
          type_d       = in_key;
        end
        2'd1: buf_d[63:32] = in_data;
        2'd2: buf_d[31:0]  = in_data;
        default: begin
          if (type_q) begin
            key_d = {buf_q, in_data};
          end else begin
            state_d = {buf_q, in_data};
            issue_d = 1'b1;
          end
        end
      endcase
    end

    vld_sr_d   = (vld_sr_q << 1) | CORE_LATENCY'(issue_q);
    inflight_d = inflight_q + CW'(issue_q) - CW'(push);
    fcnt_d     = fcnt_q + CW'(push) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    oidx_d     = (ovalid_q && out_ready) ? oidx_q + 2'd1 : oidx_q;

    // A result landing in an otherwise empty FIFO becomes the head directly
    head     = (push && ((fcnt_q - CW'(pop)) == '0)) ? core_out : mem_q[rd_ptr_d];
    ovalid_d = (fcnt_d != '0);
    odata_d  = '0;
    if (ovalid_d) begin
      unique case (oidx_d)
        2'd0:    odata_d = head[127:96];
        2'd1:    odata_d = head[95:64];
        2'd2:    odata_d = head[63:32];
        default: odata_d = head[31:0];
      endcase
    end
    olast_d = ovalid_d && (oidx_d == 2'd3);
    busy_d  = (cnt_d != 2'd0) || (inflight_d != '0) || (fcnt_d != '0) || issue_d;
    // Plaintext word 3 waits until its result is guaranteed a FIFO slot
    rdy_d   = !((cnt_d == 2'd3) && !type_d &&
                ((SW'(inflight_d) + SW'(fcnt_d) + SW'(issue_d)) >= SW'(FIFO_DEPTH)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      type_q     <= 1'b0;
      buf_q      <= '0;
      state_q    <= '0;
      key_q      <= '0;
      issue_q    <= 1'b0;
      vld_sr_q   <= '0;
      inflight_q <= '0;
      fcnt_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      oidx_q     <= '0;
      ovalid_q   <= 1'b0;
      odata_q    <= '0;
      olast_q    <= 1'b0;
      busy_q     <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      type_q     <= type_d;
      buf_q      <= buf_d;
      state_q    <= state_d;
      key_q      <= key_d;
      issue_q    <= issue_d;
      vld_sr_q   <= vld_sr_d;
      inflight_q <= inflight_d;
      fcnt_q     <= fcnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      oidx_q     <= oidx_d;
      ovalid_q   <= ovalid_d;
      odata_q    <= odata_d;
      olast_q    <= olast_d;
      busy_q     <= busy_d;
      rdy_q      <= rdy_d;
    end
  end

  // Result storage; occupancy is tracked by fcnt_q so no reset is needed
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= core_out;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (fcnt_q == CW'(FIFO_DEPTH))))
    else $error("aes_word_io: result pushed into full FIFO");

endmodule

// File: tb/tb_aes_word_io.sv
// Bench for aes_word_io: behavioural pipelined AES-128 core, vector table and
// scoreboard of expected output words.
module tb_aes_word_io;
  localparam int unsigned CORE_LATENCY = 21;
  localparam int unsigned FIFO_DEPTH   = 4;

  logic         clk, rst, in_valid, in_ready, in_key;
  logic         out_valid, out_ready, out_last, busy;
  logic [31:0]  in_data, out_data;
  logic [127:0] core_state, core_key, core_out;

  aes_word_io #(.CORE_LATENCY(CORE_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .core_state(core_state),
    .core_key(core_key), .core_out(core_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] exp;
  } vec_t;

  vec_t         tbl [6];
  logic [7:0]   sbox [256];
  logic [127:0] pipe [CORE_LATENCY];
  logic [127:0] model_key;
  logic [32:0]  sb [$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic         prev_stall = 1'b0;
  logic [32:0]  prev_word;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- AES-128 reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input int v);
    logic [7:0] b   = 8'(v);
    logic [7:0] inv = 8'h01;
    for (int k = 0; k < 254; k++) inv = gmul(inv, b);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[rr+4*c] = t[rr + 4*((c+rr)%4)];
      if (rd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Behavioural core: samples state/key each edge, result CORE_LATENCY cycles later
  always @(posedge clk) begin
    pipe[0] <= aes_enc(core_state, core_key);
    for (int i = 1; i < CORE_LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign core_out = pipe[CORE_LATENCY-1];

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Output monitor: scoreboard pop on handshake, hold check after a stalled cycle
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold", 256'({out_valid, out_last, out_data}), 256'({1'b1, prev_word}));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) fail("unexpected_word");
        else check("out_word", 256'({out_last, out_data}), 256'(sb.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_word(input logic [31:0] d, input logic k);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_key   = k;
    while (n < 300) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 300) fail("in_timeout");
    else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // in_key is inverted on words 1-3 to confirm only word 0 sets the block type
  task automatic send_block(input logic [127:0] blk, input logic is_key, input bit push_exp,
                            input logic [127:0] exp, input bit stall_chk);
    int hits = 0;
    for (int w = 0; w < 3; w++) send_word(blk[127-32*w -: 32], (w == 0) ? is_key : ~is_key);
    if (stall_chk) begin
      in_valid = 1'b1;
      in_data  = blk[31:0];
      in_key   = ~is_key;
      repeat (40) begin
        @(negedge clk);
        if (in_ready) hits++;
      end
      check("credit_stall", 256'(hits), 256'(0));
      @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    send_word(blk[31:0], ~is_key);
    if (is_key) model_key = blk;
    else if (push_exp)
      for (int w = 0; w < 4; w++) sb.push_back({1'(w == 3), exp[127-32*w -: 32]});
  endtask

  task automatic send_pt(input logic [127:0] blk);
    send_block(blk, 1'b0, 1'b1, aes_enc(blk, model_key), 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail("drain_timeout");
    @(negedge clk);
    check("idle_after", 256'({busy, out_valid}), 256'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("in_ready_in_rst", 256'(in_ready), 256'(0));
    @(posedge clk);
    #1;
    rst       = 1'b0;
    model_key = '0;
    @(negedge clk);
    check("rst_ctrl", 256'({in_ready, out_valid, out_last, busy}), 256'(4'b1000));
    check("rst_data", 256'(out_data), 256'(0));
    check("rst_core", {core_state, core_key}, 256'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] k1, k2, a, b;
    int           lat, idle_bad, nv;
    bit           seen;

    for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(i);
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = 1'b0; out_ready = 1'b0;
    model_key = '0;

    tbl[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tbl[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
               128'h3925841d02dc09fbdc118597196a0b32};
    tbl[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    tbl[3] = '{{128{1'b1}}, {128{1'b1}}, 128'h0};
    tbl[4] = '{rnd128(), rnd128(), 128'h0};
    tbl[5] = '{rnd128(), rnd128(), 128'h0};
    for (int i = 3; i < 6; i++) tbl[i].exp = aes_enc(tbl[i].pt, tbl[i].key);

    do_reset();

    // FIPS-197 vector with latency and idle core_state observation
    out_ready = 1'b1;
    send_block(tbl[0].key, 1'b1, 1'b0, '0, 1'b0);
    send_block(tbl[0].pt, 1'b0, 1'b1, tbl[0].exp, 1'b0);
    @(negedge clk);
    check("issue_state", 256'(core_state), 256'(tbl[0].pt));
    check("core_key", 256'(core_key), 256'(tbl[0].key));
    seen = 1'b0; lat = 0; idle_bad = 0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
`ifdef AES_IO_IDLE_ZERO_EN
      if (i <= 10 && core_state !== 128'h0) idle_bad++;
`else
      if (i <= 10 && core_state !== tbl[0].pt) idle_bad++;
`endif
      if (out_valid) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check("idle_state", 256'(idle_bad), 256'(0));
    check("latency", 256'(lat), 256'(CORE_LATENCY + 1));
    drain();

    // Vector table, one key+plaintext pair per record
    for (int i = 1; i < 6; i++) begin
      send_block(tbl[i].key, 1'b1, 1'b0, '0, 1'b0);
      send_block(tbl[i].pt, 1'b0, 1'b1, tbl[i].exp, 1'b0);
      drain();
    end

    // Key change immediately after a plaintext issue
    k1 = rnd128(); k2 = rnd128(); a = rnd128(); b = rnd128();
    send_block(k1, 1'b1, 1'b0, '0, 1'b0);
    send_block(a, 1'b0, 1'b1, aes_enc(a, k1), 1'b0);
    send_block(k2, 1'b1, 1'b0, '0, 1'b0);
    send_block(b, 1'b0, 1'b1, aes_enc(b, k2), 1'b0);
    drain();

    // Credit stall: 4 results parked, 5th plaintext word 3 must wait
    out_ready = 1'b0;
    send_block(tbl[1].key, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) send_pt(rnd128());
    a = rnd128();
    send_block(a, 1'b0, 1'b1, aes_enc(a, model_key), 1'b1);
    send_pt(rnd128());
    drain();

    // Output backpressure: out_ready toggles every cycle
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_pt(rnd128());
    repeat (30) @(posedge clk);
    #1;
    nv = 0;
    while (sb.size() != 0 && nv < 500) begin
      @(posedge clk);
      #1;
      out_ready = ~out_ready;
      nv++;
    end
    out_ready = 1'b1;
    drain();

    // Reset five cycles after an issue; the dropped block must never appear
    send_block(tbl[0].key, 1'b1, 1'b0, '0, 1'b0);
    send_block(tbl[0].pt, 1'b0, 1'b0, '0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    nv = 0;
    repeat (CORE_LATENCY + 10) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("dropped_block", 256'(nv), 256'(0));
    @(posedge clk);
    #1;

    // Recovery after reset
    send_block(tbl[0].key, 1'b1, 1'b0, '0, 1'b0);
    send_block(tbl[0].pt, 1'b0, 1'b1, tbl[0].exp, 1'b0);
    drain();

    check("sb_empty", 256'(sb.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_word_io.md
Name: aes_word_io

Overview:
- Word-serial front/back end for the pipelined 128-bit AES encryption core.
- Packs 32-bit input words into 128-bit key and plaintext registers, then issues one block per cycle to the core's state/key inputs.
- Tracks each block through the fixed core latency with a valid shift register.
- Captures core results in a credit-protected FIFO and returns ciphertext as 32-bit words under valid/ready.

Parameters:
- CORE_LATENCY, 21: cycles from the core sampling core_state to the matching result on core_out.
- FIFO_DEPTH, 4: result FIFO entries (128-bit each); power of two, >=2.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid&in_ready
- in_data  in  32  input word
- in_key  in  1  type of block, sampled on word 0 of a block: 1=key, 0=plaintext
- core_state  out  128  plaintext to core
- core_key  out  128  key to core
- core_out  in  128  ciphertext from core
- out_valid  out  1  output word valid
- out_ready  in  1  output word consumed when out_valid&out_ready
- out_data  out  32  output word
- out_last  out  1  high on word 3 of each result
- busy  out  1  any block partial, in flight or in FIFO

Behaviour:
- Reset (clk, rst) is synchronous and active-high. On reset, all state clears:
  - in_ready=0 during rst, 1 the cycle after.
  - out_valid=0, out_data=0, out_last=0, busy=0.
  - core_state=0, core_key=0; word counter, type flag, valid shift register, inflight counter and FIFO all cleared.
- Reset mid-operation discards partial, in-flight and queued blocks. Core results arriving after reset are ignored.
- Input assembly:
  - A 2-bit word counter counts accepted words.
  - The word-0 in_key value is latched as the block type; in_key is ignored on words 1-3.
  - Word order is MSB first: word0->[127:96], word1->[95:64], word2->[63:32], word3->[31:0].
- Key block:
  - On word-3 acceptance, core_key updates atomically on the next edge.
  - The core pipelines its key alongside the state, so blocks issued at or after that cycle use the new key. In-flight blocks are unaffected.
  - in_ready is never gated for key words.
- Plaintext block:
  - Word 3 is accepted only if credit is available: inflight + fifo_count + issue_pending < FIFO_DEPTH. Otherwise in_ready=0 while the counter is at 3 and the type is plaintext.
  - Words 0-2 are never gated.
  - On word-3 acceptance, core_state loads the full block on the next edge and issue_pending is set for exactly one cycle (issue cycle T). The core samples at the end of T.
  - Back-to-back blocks issue at most every 4 cycles.
- Valid tracking:
  - Shift register vld_sr[CORE_LATENCY-1:0] shifts each cycle; bit 0 loads issue_pending.
  - When vld_sr[CORE_LATENCY-1]=1 (cycle T+CORE_LATENCY), core_out is pushed into the FIFO.
  - inflight = popcount of vld_sr, kept as a counter: +1 on issue, -1 on push.
- FIFO:
  - The push never finds the FIFO full, by the credit rule. A push while full is a design error; flag it with a simulation assertion.
  - Push and pop of the same entry in one cycle is legal. Counts update as +1 -1 = 0.
- Output:
  - The head entry is serialized as 4 words, MSB first; out_last=1 on word 3.
  - The entry is popped on handshake of word 3.
  - out_data and out_last hold stable while out_valid&!out_ready.
  - out_valid drops the cycle after the final pop if the FIFO is empty.
- busy = (counter!=0) | inflight!=0 | fifo_count!=0 | issue_pending.
- Counter wrap: after word 3 the counter returns to 0, and the next word is word 0 of a new block.

Optional Feature:
- Macro: AES_IO_IDLE_ZERO_EN.
- Defined: core_state is driven to 128'h0 in every cycle other than an issue cycle, so the core sees plaintext only in T.
- Undefined: core_state holds the last issued block until the next issue.
- Key, latency and output behaviour are identical in both builds. Results from idle cycles are never captured, because vld_sr is 0 for them.

Test Plan:
- FIPS-197 vector:
  - Stimulus: key words 00010203,04050607,08090a0b,0c0d0e0f (in_key=1); plaintext 00112233,44556677,8899aabb,ccddeeff (in_key=0); out_ready=1.
  - Response: out_data 69c4e0d8,6a7b0430,d8cdb780,70b4c55a with out_last on the 4th word; first output word exactly CORE_LATENCY+1 cycles after the issue cycle; busy=0 afterwards.
- Credit stall:
  - Stimulus: out_ready=0; stream 6 plaintext blocks (FIFO_DEPTH=4).
  - Response: in_ready=0 on word 3 of block 5; no FIFO overflow assertion. Then out_ready=1: blocks 5 and 6 are accepted, all 6 results are returned in order, and each matches the reference model.
- Key change between blocks:
  - Stimulus: issue PT block A with key K1, load K2 immediately, then issue PT block B.
  - Response: A encrypted with K1, B with K2.
- Output backpressure:
  - Stimulus: toggle out_ready every cycle during output.
  - Response: out_data stable whenever out_valid&!out_ready; 4 words per block; no word lost or duplicated.
- Reset mid-flight:
  - Stimulus: assert rst for 1 cycle 5 cycles after an issue.
  - Response: all outputs 0 and busy=0 the next cycle. No out_valid ever appears for the dropped block, even at T+CORE_LATENCY.
- Idle zero (both builds):
  - Stimulus: observe core_state in cycles T+1..T+10.
  - Response: 0 with AES_IO_IDLE_ZERO_EN defined; the last issued block without it.
